// File: rtl/hex_display_driver_if.sv
// Load handshake bundle for hex_display_driver.
// master drives the update request; slave is the driver.
interface hex_display_driver_if #(
  parameter int NUM_DIGITS = 6
);
  logic [4*NUM_DIGITS-1:0] value;
  logic                    lz_en;
  logic                    load;
  logic                    ready;
  logic                    done;

  modport master (
    output value, lz_en, load,
    input  ready, done
  );

  modport slave (
    input  value, lz_en, load,
    output ready, done
  );
endinterface

// File: rtl/hex_display_driver.sv
// Multi-digit 7-segment driver: one shared decoder scans digits into
// a shadow register, then commits them together; LZ blanking + blink.
module hex_display_driver #(
  parameter int NUM_DIGITS = 6,
  parameter int ACTIVE_LOW = 1,
  parameter int BLINK_DIV  = 25000000
)(
  input  logic                    clk,
  input  logic                    resetn,
  hex_display_driver_if.slave     bus,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [7*NUM_DIGITS-1:0] segs
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = $clog2(BLINK_DIV);
  localparam logic [IW-1:0] TOP  = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] CMAX = CW'(BLINK_DIV - 1);
  localparam logic [6:0] OFF =
    (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    COMMIT
  } state_t;

  state_t state, state_n;

  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] val_q;
  logic                    lz_q;
  logic                    ready_q;
  logic                    done_q;
  logic [6:0]              shadow [NUM_DIGITS];
  logic [6:0]              shown  [NUM_DIGITS];
  logic [CW-1:0]           cnt;
  logic                    phase;
  logic                    accept;
  logic [3:0]              nib;
  logic [6:0]              glyph;
  logic                    blank_d;
  logic [7*NUM_DIGITS-1:0] segs_n;

  assign accept    = (state == IDLE) && bus.load && ready_q;
  assign bus.ready = ready_q;
  assign bus.done  = done_q;

  // Select the nibble being scanned and decide LZ blanking for it.
  always_comb begin
    nib     = val_q[{idx, 2'b00} +: 4];
    blank_d = lz_q && (nib == 4'h0) && (idx != '0);
  end

  // Shared hex decoder, lit-high form (bit0 = a ... bit6 = g).
  always_comb begin
    glyph = 7'h00;
    unique case (nib)
      4'h0: glyph = 7'h3F;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;
      4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;
      4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;
      4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;
      4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;
      4'hF: glyph = 7'h71;
    endcase
  end

  // Next-state logic: IDLE -> SCAN -> COMMIT -> IDLE.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (accept) state_n = SCAN;
      SCAN:    if (idx == '0) state_n = COMMIT;
      COMMIT:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State register, capture, scan index, handshake outputs.
  // ready stays low through the cycle done is high.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      idx     <= '0;
      val_q   <= '0;
      lz_q    <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      done_q  <= (state == COMMIT);
      ready_q <= (state == IDLE) && !accept;
      if (accept) begin
        val_q <= bus.value;
        lz_q  <= bus.lz_en;
        idx   <= TOP;
      end else if (state == SCAN) begin
        idx <= idx - 1'b1;
        if (nib != 4'h0) lz_q <= 1'b0;
      end
    end
  end

  // Shadow fill during scan; committed copy swaps in at COMMIT.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow[i] <= 7'h00;
        shown[i]  <= 7'h00;
      end
    end else begin
      if (state == SCAN)
        shadow[idx] <= blank_d ? 7'h00 : glyph;
      if (state == COMMIT)
        for (int i = 0; i < NUM_DIGITS; i++)
          shown[i] <= shadow[i];
    end
  end

  // Free-running blink timebase; phase flips on each wrap.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (cnt == CMAX) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Output mux: committed (or committing) digits with blink gating.
  always_comb begin
    logic [6:0] lit;
    lit    = 7'h00;
    segs_n = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      lit = (state == COMMIT) ? shadow[i] : shown[i];
      if (phase && blink_mask[i]) lit = 7'h00;
      segs_n[7*i +: 7] = (ACTIVE_LOW != 0) ? ~lit : lit;
    end
  end

  // Registered segment outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) segs <= {NUM_DIGITS{OFF}};
    else         segs <= segs_n;
  end

endmodule

// File: tb/tb_hex_display_driver.sv
// Bench for hex_display_driver: cycle model from behavioural rules
// plus directed vectors with literal expectations.
module tb_hex_display_driver;

  localparam int ND = 6;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [ND-1:0] blink_mask = '0;
  logic [7*ND-1:0] segs;

  hex_display_driver_if #(.NUM_DIGITS(ND)) bus ();

  hex_display_driver #(
    .NUM_DIGITS(ND),
    .ACTIVE_LOW(1),
    .BLINK_DIV(4)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus),
    .blink_mask(blink_mask),
    .segs(segs)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int done_seen = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Active-low glyph table for hex 0..F.
  logic [6:0] gl [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Model state.
  logic [7*ND-1:0] exp_segs = '1;
  logic exp_ready = 1'b1;
  logic exp_done = 1'b0;
  logic [6:0] mcom [ND];
  logic [6:0] pgl [ND];
  logic pend = 1'b0;
  int cyc = 0;
  int commit_at = 0;
  int ready_at = 0;
  int bcnt = 0;
  logic bph = 1'b0;
  int hi;

  // Behavioural model: a load accepted on edge N shows on edge N+7,
  // ready returns on edge N+8; blink phase flips every 4 edges.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < ND; i++) mcom[i] = 7'h7F;
      exp_segs = '1;
      exp_ready = 1'b1;
      exp_done = 1'b0;
      pend = 1'b0;
      cyc = 0;
      bcnt = 0;
      bph = 1'b0;
    end else begin
      cyc++;
      exp_done = 1'b0;
      if (pend && cyc == commit_at) begin
        for (int i = 0; i < ND; i++) mcom[i] = pgl[i];
        exp_done = 1'b1;
        pend = 1'b0;
      end
      for (int i = 0; i < ND; i++)
        exp_segs[7*i +: 7] = (bph && blink_mask[i]) ? 7'h7F : mcom[i];
      if (exp_ready && bus.load) begin
        hi = 0;
        for (int i = 0; i < ND; i++)
          if (bus.value[4*i +: 4] != 4'h0) hi = i;
        for (int i = 0; i < ND; i++)
          pgl[i] = (bus.lz_en && i > hi) ? 7'h7F : gl[bus.value[4*i +: 4]];
        pend = 1'b1;
        commit_at = cyc + 7;
        ready_at = cyc + 8;
        exp_ready = 1'b0;
      end else if (!exp_ready && cyc == ready_at) begin
        exp_ready = 1'b1;
      end
      bcnt++;
      if (bcnt == 4) begin
        bcnt = 0;
        bph = ~bph;
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    chk("segs", 64'(segs), 64'(exp_segs));
    chk("ready", 64'(bus.ready), 64'(exp_ready));
    chk("done", 64'(bus.done), 64'(exp_done));
    if (bus.done === 1'b1) done_seen++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [4*ND-1:0] v, input logic lz);
    @(negedge clk);
    bus.value = v;
    bus.lz_en = lz;
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  int d0;
  logic s12, s7f;

  initial begin
    bus.value = '0;
    bus.lz_en = 1'b0;
    bus.load = 1'b0;

    // Reset state.
    tick(3);
    chk("rst_segs", 64'(segs), 64'h3FF_FFFF_FFFF);
    chk("rst_ready", 64'(bus.ready), 64'd1);
    chk("rst_done", 64'(bus.done), 64'd0);
    #1 resetn = 1'b1;
    tick(4);
    chk("idle_segs", 64'(segs), 64'h3FF_FFFF_FFFF);
    chk("idle_ready", 64'(bus.ready), 64'd1);

    // Plain decode.
    do_load(24'h0123AF, 1'b0);
    tick(7);
    chk("t2_done", 64'(bus.done), 64'd1);
    chk("t2_segs", 64'(segs),
        64'({7'h40, 7'h79, 7'h24, 7'h30, 7'h08, 7'h0E}));
    tick(1);
    chk("t2_ready", 64'(bus.ready), 64'd1);

    // Leading-zero blanking.
    do_load(24'h0123AF, 1'b1);
    tick(7);
    chk("t3_segs", 64'(segs),
        64'({7'h7F, 7'h79, 7'h24, 7'h30, 7'h08, 7'h0E}));
    tick(1);
    do_load(24'h000000, 1'b1);
    tick(7);
    chk("t3_zero", 64'(segs),
        64'({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}));
    tick(1);

    // Load while busy is dropped; mid-scan input changes ignored.
    d0 = done_seen;
    do_load(24'hFEDCBA, 1'b0);
    do_load(24'h111111, 1'b1);
    bus.value = 24'h999999;
    tick(10);
    chk("t4_segs", 64'(segs),
        64'({7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08}));
    chk("t4_ndone", 64'(done_seen - d0), 64'd1);

    // Blink on digit 0.
    blink_mask = 6'b000001;
    do_load(24'h000005, 1'b0);
    tick(9);
    s12 = 1'b0;
    s7f = 1'b0;
    for (int k = 0; k < 16; k++) begin
      tick(1);
      if (segs[6:0] == 7'h12) s12 = 1'b1;
      if (segs[6:0] == 7'h7F) s7f = 1'b1;
    end
    chk("t5_on", 64'(s12), 64'd1);
    chk("t5_off", 64'(s7f), 64'd1);
    chk("t5_hi", 64'(segs[41:7]), 64'({5{7'h40}}));
    blink_mask = '0;
    tick(1);
    chk("t5_clear", 64'(segs[6:0]), 64'h12);

    // Reset mid-scan abandons the update.
    d0 = done_seen;
    do_load(24'h654321, 1'b0);
    tick(3);
    #1 resetn = 1'b0;
    tick(1);
    chk("t6_blank", 64'(segs), 64'h3FF_FFFF_FFFF);
    chk("t6_ready", 64'(bus.ready), 64'd1);
    #1 resetn = 1'b1;
    tick(10);
    chk("t6_nodone", 64'(done_seen - d0), 64'd0);
    chk("t6_still", 64'(segs), 64'h3FF_FFFF_FFFF);
    do_load(24'hC0FFEE, 1'b0);
    tick(7);
    chk("t6_done", 64'(bus.done), 64'd1);
    chk("t6_segs", 64'(segs),
        64'({7'h46, 7'h40, 7'h0E, 7'h0E, 7'h06, 7'h06}));
    tick(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
